// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with a start/busy/done
// handshake. One conversion takes WIDTH shift cycles after acceptance.
// Optional feature macro: BIN_TO_BCD_SIGNED_EN (two's complement input,
// magnitude converted, sign reported alongside bcd_out).
//
//   state | meaning
//   IDLE  | waiting for start; bcd_out/sign hold the last result
//   SHIFT | one add-3 correction plus left shift per cycle, WIDTH cycles
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  sign
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  // Decimal digits needed to show the largest unsigned WIDTH-bit value.
  function automatic int dec_digits(input int w);
    longint unsigned v;
    int n;
    v = (64'd1 << w) - 64'd1;
    n = 0;
    while (v != 0) begin
      v = v / 10;
      n = n + 1;
    end
    if (n == 0) n = 1;
    return n;
  endfunction

  if (DIGITS < dec_digits(WIDTH)) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
  end

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]    scratch_q, scratch_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             done_q, done_d;
  logic [BW-1:0]    corrected;
  logic [BW-1:0]    shifted;
  logic [WIDTH-1:0] load_val;

`ifdef BIN_TO_BCD_SIGNED_EN
  logic sign_r_q, sign_r_d;
  logic sign_q, sign_d;

  // Magnitude of the two's complement operand; -2^(WIDTH-1) maps onto itself
  // as an unsigned value, which is the correct magnitude.
  always_comb begin
    load_val = bin_in[WIDTH-1] ? ((~bin_in) + WIDTH'(1)) : bin_in;
  end
`else
  // Unsigned build: operand loads as-is.
  always_comb begin
    load_val = bin_in;
  end
`endif

  // Add-3 correction on each digit >= 5, then shift in the binary MSB.
  always_comb begin
    corrected = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5)
        corrected[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
    shifted = {corrected[BW-2:0], bin_q[WIDTH-1]};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
`ifdef BIN_TO_BCD_SIGNED_EN
    sign_r_d  = sign_r_q;
    sign_d    = sign_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d     = load_val;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = SHIFT;
`ifdef BIN_TO_BCD_SIGNED_EN
          sign_r_d  = bin_in[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        scratch_d = shifted;
        bin_d     = {bin_q[WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          bcd_d   = shifted;
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef BIN_TO_BCD_SIGNED_EN
          sign_d  = sign_r_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
    end
  end

`ifdef BIN_TO_BCD_SIGNED_EN
  // Sign captured at acceptance, published together with bcd_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_r_q <= 1'b0;
      sign_q   <= 1'b0;
    end else begin
      sign_r_q <= sign_r_d;
      sign_q   <= sign_d;
    end
  end

  assign sign = sign_q;
`else
  assign sign = 1'b0;
`endif

  assign busy    = (state_q == SHIFT);
  assign done    = done_q;
  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int BW     = 4 * DIGITS;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] bin_in;
  logic             busy;
  logic             done;
  logic [BW-1:0]    bcd_out;
  logic             sign;

  typedef struct {
    logic [BW-1:0] bcd;
    logic          sgn;
    int            acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_mis;
  int   cyc;

  bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .sign    (sign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain decimal arithmetic on the magnitude.
  function automatic exp_t model(input logic [WIDTH-1:0] v);
    exp_t e;
    logic [WIDTH-1:0] m;
    int n;
`ifdef BIN_TO_BCD_SIGNED_EN
    e.sgn = v[WIDTH-1];
    m = v[WIDTH-1] ? WIDTH'(0 - int'(v)) : v;
`else
    e.sgn = 1'b0;
    m = v;
`endif
    n = int'(m);
    e.bcd = {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    e.acc = 0;
    return e;
  endfunction

  task automatic push_exp(input logic [WIDTH-1:0] v, input int acc);
    exp_t e;
    e = model(v);
    e.acc = acc;
    sb.push_back(e);
  endtask

  // Wait for done (bounded); returns whether it came and busy observations.
  task automatic wait_done(output bit got, output int busy_seen);
    got = 1'b0;
    busy_seen = 0;
    for (int k = 0; k < WIDTH + 4; k++) begin
      @(posedge clk); #1;
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) busy_seen++;
    end
  endtask

  task automatic run_one(input logic [WIDTH-1:0] v, input string nm);
    bit   got;
    int   bs;
    exp_t e;
    @(negedge clk);
    bin_in = v;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    push_exp(v, cyc);
    bs = busy ? 1 : 0;
    wait_done(got, e.acc);
    bs += e.acc;
    n_cmp++;
    if (!got) begin
      n_mis++;
      $display("FAIL %s timeout: no done within %0d cycles", nm, WIDTH + 4);
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    if (cyc - e.acc !== WIDTH) begin
      n_mis++;
      $display("FAIL %s latency: got %0d expected %0d", nm, cyc - e.acc, WIDTH);
    end
    n_cmp++;
    if (bcd_out !== e.bcd || sign !== e.sgn) begin
      n_mis++;
      $display("FAIL %s result: got bcd=%h sign=%b expected bcd=%h sign=%b",
               nm, bcd_out, sign, e.bcd, e.sgn);
    end
    n_cmp++;
    if (bs !== WIDTH || busy !== 1'b0) begin
      n_mis++;
      $display("FAIL %s busy: got %0d busy cycles (busy at done=%b) expected %0d (0)",
               nm, bs, busy, WIDTH);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0) begin
      n_mis++;
      $display("FAIL %s done_width: got done=%b one cycle later expected 0", nm, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== '0 || sign !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_state: got busy=%b done=%b bcd=%h sign=%b expected 0 0 000 0",
               busy, done, bcd_out, sign);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_values();
    logic [WIDTH-1:0] vals [7];
    vals = '{8'd0, 8'd255, 8'd99, 8'd100, 8'h80, 8'hFF, 8'h7F};
    foreach (vals[i]) run_one(vals[i], $sformatf("value_%0d", vals[i]));
  endtask

  task automatic test_back_to_back();
    bit   got;
    int   bs;
    exp_t e;
    @(negedge clk);
    bin_in = 8'd128;
    start  = 1'b1;
    @(posedge clk); #1;
    push_exp(8'd128, cyc);
    @(negedge clk);
    bin_in = 8'd7;
    wait_done(got, bs);
    n_cmp++;
    if (!got) begin
      n_mis++;
      $display("FAIL b2b_first timeout: no done");
      start = 1'b0;
      sb.delete();
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    if (cyc - e.acc !== WIDTH || bcd_out !== e.bcd) begin
      n_mis++;
      $display("FAIL b2b_first: got latency=%0d bcd=%h expected %0d %h",
               cyc - e.acc, bcd_out, WIDTH, e.bcd);
    end
    @(posedge clk); #1;
    start = 1'b0;
    push_exp(8'd7, cyc);
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_mis++;
      $display("FAIL b2b_accept: got busy=%b done=%b expected 1 0", busy, done);
    end
    wait_done(got, bs);
    n_cmp++;
    if (!got) begin
      n_mis++;
      $display("FAIL b2b_second timeout: no done");
      sb.delete();
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    if (cyc - e.acc !== WIDTH || bcd_out !== e.bcd) begin
      n_mis++;
      $display("FAIL b2b_second: got latency=%0d bcd=%h expected %0d %h",
               cyc - e.acc, bcd_out, WIDTH, e.bcd);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    bit seen_done;
    @(negedge clk);
    bin_in = 8'd200;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    push_exp(8'd200, cyc);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    void'(sb.pop_front());
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== '0) begin
      n_mis++;
      $display("FAIL abort_state: got busy=%b done=%b bcd=%h expected 0 0 000",
               busy, done, bcd_out);
    end
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < WIDTH + 3; k++) begin
      @(posedge clk); #1;
      if (done || busy) seen_done = 1'b1;
    end
    n_cmp++;
    if (seen_done !== 1'b0 || bcd_out !== '0) begin
      n_mis++;
      $display("FAIL abort_quiet: got activity=%b bcd=%h expected 0 000",
               seen_done, bcd_out);
    end
    run_one(8'd42, "after_abort_42");
  endtask

  task automatic test_exhaustive();
    for (int v = 0; v < 256; v++) run_one(WIDTH'(v), $sformatf("exh_%0d", v));
  endtask

  initial begin
    n_cmp  = 0;
    n_mis  = 0;
    start  = 1'b0;
    bin_in = '0;
    rst    = 1'b0;
    #2;
    test_reset();
    test_values();
    test_back_to_back();
    test_reset_abort();
    test_exhaustive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
